cmp128_arbiter: RTL
===================

Name: cmp128_arbiter

Overview:
- Shares one 128-bit magnitude comparator tree (comparatortree128) among NREQ requesters.
- Round-robin arbitration, valid/ready request and response handshakes, registered operands and results.
- Each requester selects a signed or unsigned compare.
- Sits between the requester datapaths (e.g. a 128-bit min/max unit or a bounds checker) and the single comparator instance, so the tree is not replicated.

Parameters:
- NREQ, 4, number of requesters; legal range 2..16.
- IDW, $clog2(NREQ), localparam; width of the requester index.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant/accept; one-hot or zero.
- req_a  input  NREQ*128  operand A, requester i at [128*i+127:128*i].
- req_b  input  NREQ*128  operand B, same packing.
- req_signed  input  NREQ  1 = two's-complement compare, 0 = unsigned.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  IDW  index of the requester whose result is presented.
- rsp_lt  output  1  A < B under the selected signedness.
- rsp_eq  output  1  A == B.
- rsp_gt  output  1  A > B; equals ~rsp_lt & ~rsp_eq.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, active-high) is valid at any time, including mid-operation:
  - FSM = IDLE; rsp_valid/rsp_lt/rsp_eq/rsp_gt = 0; rsp_id = 0; busy = 0.
  - Round-robin pointer last_grant = NREQ-1, so requester 0 has top priority after reset.
  - Operand registers cleared; any in-flight request is dropped and never answered.
- FSM states:
  - IDLE -> CMP: on acceptance.
  - CMP -> RESP: unconditional, after 1 cycle.
  - RESP -> IDLE: when rsp_ready=1.
  - RESP holds while rsp_ready=0.
- Arbitration (IDLE only; combinational):
  - Scan from last_grant+1 upward, wrapping NREQ-1 -> 0.
  - The first i with req_valid[i]=1 gets req_ready[i]=1. All other req_ready = 0.
  - In CMP/RESP, req_ready = 0.
- Acceptance and capture:
  - Acceptance = req_valid[i] & req_ready[i] at a rising edge.
  - At that edge: req_a[i], req_b[i] and req_signed[i] are captured into op_a, op_b, op_s; i goes into id_q; last_grant <= i.
  - last_grant changes only on acceptance.
- Requester obligations: hold req_valid and payload until accepted. Withdrawing before acceptance is permitted; arbitration is re-evaluated each cycle.
- Compare:
  - The comparator is fed only from op_a/op_b (no combinational path from req_* to rsp_*).
  - At the CMP->RESP edge:
    - rsp_lt <= op_s ? LT : LTu.
    - rsp_eq <= EQ.
    - rsp_gt <= ~lt & ~eq.
    - rsp_id <= id_q.
    - rsp_valid <= 1.
- Latency: acceptance at edge E0 -> rsp_valid high after E1.
- Response hold: rsp_valid and rsp_* stay stable until rsp_ready=1 at an edge. That edge clears rsp_valid; the result fields hold their last values.
- Throughput: one compare per 3 cycles minimum (IDLE, CMP, RESP).
- No starvation: a requester holding req_valid is granted within NREQ acceptances.

Optional Feature:
- Macro: CMP128_ARB_BACKTOBACK_EN.
- When defined: in RESP with rsp_ready=1, arbitration also runs and req_ready may assert.
  - Acceptance at that edge goes RESP -> CMP directly. rsp_valid drops for exactly one cycle (CMP) and re-asserts after the next edge.
  - Throughput becomes one compare per 2 cycles.
- When undefined: behaviour exactly as above; req_ready is never asserted outside IDLE.

Test Plan:
1. Reset, then only req_valid[2]=1 with A=0x5, B=0x7, signed=0 -> req_ready=4'b0100 in the same cycle; rsp_valid rises 2 edges later with rsp_id=2, lt=1, eq=0, gt=0.
2. Signed vs unsigned: A=0x8000...0000, B=0x1 -> signed=1 gives lt=1; signed=0 gives gt=1. A=B=0xFFFF...FFFF gives eq=1, lt=0, gt=0.
3. Round-robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; no req_ready outside IDLE (or RESP with the macro defined).
4. Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable, busy=1, all req_ready=0; rsp_ready=1 -> rsp_valid=0 next cycle, FSM in IDLE.
5. Reset asserted asynchronously during CMP (between edges) -> outputs zero immediately. After release with req_valid=4'b1111, requester 0 is granted first; the dropped request produces no rsp_valid.
6. With CMP128_ARB_BACKTOBACK_EN: req_valid[1] and req_valid[3] held, rsp_ready=1 -> rsp_valid pattern 1,0,1,0 with rsp_id alternating 1,3. Without the macro -> pattern 1,0,0,1.

Source files
------------

// File: rtl/cmp128_arbiter.sv
// cmp128_arbiter: round-robin front end that lets NREQ requesters share one
// 128-bit magnitude comparator. Each request has operands A and B and a
// signed/unsigned select. Operands and results are registered, so the
// comparator sees only the captured operands and never the live request bus.
//
// Optional build macro: CMP128_ARB_BACKTOBACK_EN
//   When defined, a new request can be accepted in the same cycle that a
//   response is consumed (RESP -> CMP). One compare then takes 2 cycles
//   instead of 3.
//
// Handshake semantics (both request and response sides):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The producer holds valid and payload stable until that edge. A requester
//   may drop req_valid before it is accepted. Arbitration is recomputed every
//   cycle. req_ready is one-hot or zero and depends combinationally on
//   req_valid. rsp_valid does not depend on rsp_ready. Once raised, rsp_valid
//   and rsp_* stay stable until the transfer edge.

// Shared 128-bit comparator. It gives unsigned less-than, signed less-than
// and equality. Byte lanes are compared first and then merged from the most
// significant lane down.
module comparatortree128 (
    input  logic [127:0] a,
    input  logic [127:0] b,
    output logic         lt_u,
    output logic         lt_s,
    output logic         eq
);
    logic [15:0] lane_lt;
    logic [15:0] lane_eq;
    logic        lt_acc;
    logic        eq_acc;

    // Per-byte-lane less-than and equality.
    always_comb begin
        lane_lt = '0;
        lane_eq = '0;
        for (int i = 0; i < 16; i++) begin
            lane_lt[i] = (a[8*i +: 8] < b[8*i +: 8]);
            lane_eq[i] = (a[8*i +: 8] == b[8*i +: 8]);
        end
    end

    // Merge lanes: the most significant lane that differs decides the result.
    always_comb begin
        lt_acc = 1'b0;
        eq_acc = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            lt_acc = lt_acc | (eq_acc & lane_lt[i]);
            eq_acc = eq_acc & lane_eq[i];
        end
    end

    assign lt_u = lt_acc;
    assign eq   = eq_acc;
    // If the sign bits differ, the operand with the sign bit set is smaller.
    assign lt_s = (a[127] ^ b[127]) ? a[127] : lt_acc;
endmodule

module cmp128_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*128-1:0] req_a,
    input  logic [NREQ*128-1:0] req_b,
    input  logic [NREQ-1:0]     req_signed,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic                rsp_lt,
    output logic                rsp_eq,
    output logic                rsp_gt,
    output logic                busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    // state is the FSM observation point for external checkers.
    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] scan_idx;
    logic [IDW-1:0] id_q;
    logic           grant_found;
    logic           arb_en;
    logic           accept;
    logic [127:0]   sel_a;
    logic [127:0]   sel_b;
    logic [127:0]   op_a;
    logic [127:0]   op_b;
    logic           op_s;
    logic           cmp_lt_u;
    logic           cmp_lt_s;
    logic           cmp_eq;
    logic           lt_sel;

    comparatortree128 u_cmp (
        .a    (op_a),
        .b    (op_b),
        .lt_u (cmp_lt_u),
        .lt_s (cmp_lt_s),
        .eq   (cmp_eq)
    );

    assign lt_sel = op_s ? cmp_lt_s : cmp_lt_u;
    assign busy   = (state != IDLE);

    // Arbitration is allowed in IDLE, and with back-to-back enabled, also in
    // a RESP cycle whose response is being consumed.
    always_comb begin
        arb_en = (state == IDLE);
`ifdef CMP128_ARB_BACKTOBACK_EN
        if (state == RESP && rsp_ready) begin
            arb_en = 1'b1;
        end
`endif
    end

    // Round-robin scan starting just after last_grant and wrapping at NREQ-1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (int'(last_grant) + k >= NREQ) begin
                scan_idx = IDW'(int'(last_grant) + k - NREQ);
            end else begin
                scan_idx = IDW'(int'(last_grant) + k);
            end
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // One-hot grant to the winning requester, gated by the arbitration window.
    always_comb begin
        req_ready = '0;
        if (arb_en && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // A grant only goes to a requester whose valid is set, so granting implies acceptance.
    assign accept = arb_en & grant_found;

    // Select the winner's operands for capture.
    always_comb begin
        sel_a = req_a[int'(grant_idx)*128 +: 128];
        sel_b = req_b[int'(grant_idx)*128 +: 128];
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = CMP;
                end
            end
            CMP: begin
                state_nx = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = accept ? CMP : IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Capture the accepted operands, then register the comparator result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a       <= '0;
            op_b       <= '0;
            op_s       <= 1'b0;
            id_q       <= '0;
            last_grant <= IDW'(NREQ - 1);
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_lt     <= 1'b0;
            rsp_eq     <= 1'b0;
            rsp_gt     <= 1'b0;
        end else begin
            if (accept) begin
                op_a       <= sel_a;
                op_b       <= sel_b;
                op_s       <= req_signed[grant_idx];
                id_q       <= grant_idx;
                last_grant <= grant_idx;
            end
            if (state == CMP) begin
                rsp_valid <= 1'b1;
                rsp_lt    <= lt_sel;
                rsp_eq    <= cmp_eq;
                rsp_gt    <= ~lt_sel & ~cmp_eq;
                rsp_id    <= id_q;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule
